fetch_unit: RTL

- Instruction-fetch stage directly upstream of the MIPS control decoder and datapath.
- Owns the PC register and issues requests to a variable-latency instruction memory.
- Holds each returned instruction stable (instr / instr_valid) until the execute stage accepts it.
- On acceptance, computes the next PC from the decoder's pcsrc and jump outputs and the sign-extended immediate.

---
 rtl/fetch_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from a variable-latency
// instruction memory and holds each one until the execute stage accepts it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               pcsrc,
  input  logic               jump,
  input  logic [31:0]        signimm,
  output logic [31:0]        pc,
  output logic [31:0]        pcplus4,
  output logic [COUNT_W-1:0] retired
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          instr_q, instr_d;
  logic [COUNT_W-1:0]   retired_q, retired_d;
  logic [31:0]          pcplus4_w;
  logic [31:0]          pcbranch;
  logic [31:0]          pcjump;
  logic [31:0]          pcnext;

  // All adds are 32-bit with the carry dropped, so both targets wrap.
  always_comb begin
    pcplus4_w = pc_q + 32'd4;
    pcbranch  = pcplus4_w + (signimm << 2);
    pcjump    = {pcplus4_w[31:28], instr_q[25:0], 2'b00};
    if (jump) begin
      pcnext = pcjump;
    end else if (pcsrc) begin
      pcnext = pcbranch;
    end else begin
      pcnext = pcplus4_w;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          pc_d      = pcnext;
          retired_d = retired_q + COUNT_W'(1);
          state_d   = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC_ALIGNED;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == HOLD);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pcplus4     = pcplus4_w;
  assign instr       = instr_q;
  assign retired     = retired_q;

endmodule
